// File: rtl/fifo_pkg.sv
// Shared definitions for both sides of the 8-entry dual-port byte FIFO.
// Contents:
//   FIFO_DEPTH / FIFO_DATA_W / FIFO_ADDR_W - default geometry
//   bin2gray / gray2bin                    - pointer code conversions
// The conversions work on 32-bit vectors so that any pointer width up to
// 32 bits can use them. Callers zero-extend the pointer on the way in and
// truncate the result on the way out.
package fifo_pkg;

    localparam int FIFO_DEPTH  = 8;
    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_ADDR_W = $clog2(FIFO_DEPTH);

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of every Gray bit at or above it.
    // Zero upper bits leave the low bits unaffected.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry output buffer that absorbs the one-cycle memory read latency.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write data_in at the tail (one cycle after a memory read)
//   data_in     - memory read data
//   buf_cnt     - number of held entries (0..2)
//   m_valid_o   - registered stream valid (buffer not empty)
//   m_data_o    - registered stream data (buffer head)
//   m_ready_i   - downstream ready
// The controller guarantees that push never happens while two entries are
// held without a simultaneous pop.
module fifo_out_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    output logic [1:0]        buf_cnt,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    input  logic              m_ready_i
);

    logic [DATA_W-1:0] entry_reg [2];
    logic              rd_idx_reg, wr_idx_reg;
    logic [1:0]        cnt_reg, cnt_next;
    logic              rd_idx_next;
    logic              pop;
    logic [DATA_W-1:0] head_next;

    assign pop     = m_valid_o & m_ready_i;
    assign buf_cnt = cnt_reg;

    always_comb begin
        cnt_next    = cnt_reg + {1'b0, push} - {1'b0, pop};
        rd_idx_next = rd_idx_reg ^ pop;
        // The entry that becomes the head may be the one being written in
        // this same cycle, so bypass the incoming data in that case.
        if (push && (wr_idx_reg == rd_idx_next)) begin
            head_next = data_in;
        end else begin
            head_next = entry_reg[rd_idx_next];
        end
        // Keep the last value on the bus once the buffer runs dry.
        if (cnt_next == 2'd0) begin
            head_next = m_data_o;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entry_reg[wr_idx_reg] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx_reg <= 1'b0;
            wr_idx_reg <= 1'b0;
            cnt_reg    <= 2'd0;
            m_valid_o  <= 1'b0;
            m_data_o   <= '0;
        end else begin
            rd_idx_reg <= rd_idx_next;
            wr_idx_reg <= wr_idx_reg ^ push;
            cnt_reg    <= cnt_next;
            m_valid_o  <= (cnt_next != 2'd0);
            m_data_o   <= head_next;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-port byte FIFO.
// Compares the local binary read pointer against the synchronised Gray write
// pointer, issues memory reads, and streams the data out through a 2-entry
// buffer at up to one byte per cycle.
// Ports:
//   clk, rst_n      - read clock, asynchronous active-low reset
//   wr_ptr_gray_i   - synchronised Gray write pointer (ADDR_W+1 bits)
//   mem_rd_en_o     - memory read strobe
//   mem_rd_addr_o   - memory read address (low bits of the read pointer)
//   mem_data_i      - memory read data, valid the cycle after the strobe
//   rd_ptr_gray_o   - registered Gray read pointer for the write domain
//   m_valid_o / m_data_o / m_ready_i - output stream
//   empty_o         - no unread entries
//   level_o         - unread memory entries
//   overflow_err_o  - sticky: level exceeded DEPTH
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int DATA_W = FIFO_DATA_W,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W:0]   wr_ptr_gray_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [ADDR_W:0]   rd_ptr_gray_o,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    input  logic              m_ready_i,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_err_o
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_LIM = PTR_W'(DEPTH);

    logic [PTR_W-1:0] rd_bin_reg, rd_bin_next;
    logic [PTR_W-1:0] rd_gray_reg;
    logic [PTR_W-1:0] wr_bin;
    logic             inflight_reg;
    logic             overflow_reg;
    logic [1:0]       buf_cnt;
    logic [2:0]       occupancy;
    logic             over_now;
    logic             pop;
    logic             rd_en;

    assign wr_bin      = PTR_W'(gray2bin(32'(wr_ptr_gray_i)));
    assign level_o     = wr_bin - rd_bin_reg;
    assign empty_o     = (level_o == '0);
    assign over_now    = (level_o > DEPTH_LIM);
    assign pop         = m_valid_o & m_ready_i;
    assign rd_bin_next = rd_bin_reg + 1'b1;

    // Entries held or on their way (buffered plus in flight from memory)
    // must leave room for the new read after this cycle's pop.
    assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight_reg};
    assign rd_en     = rst_n & ~empty_o & ~over_now
                     & (occupancy < (3'd2 + {2'b00, pop}));

    assign mem_rd_en_o    = rd_en;
    assign mem_rd_addr_o  = rd_bin_reg[ADDR_W-1:0];
    assign rd_ptr_gray_o  = rd_gray_reg;
    assign overflow_err_o = overflow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bin_reg   <= '0;
            rd_gray_reg  <= '0;
            inflight_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_bin_reg  <= rd_bin_next;
                rd_gray_reg <= PTR_W'(bin2gray(32'(rd_bin_next)));
            end
            // Cleared by reset, so a read returning after reset is dropped.
            inflight_reg <= rd_en;
            overflow_reg <= overflow_reg | over_now;
        end
    end

    fifo_out_buf #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_reg),
        .data_in   (mem_data_i),
        .buf_cnt   (buf_cnt),
        .m_valid_o (m_valid_o),
        .m_data_o  (m_data_o),
        .m_ready_i (m_ready_i)
    );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a byte memory model answers reads, the stimulus
// process queues the expected bytes as it makes them available, and a
// negedge monitor compares every accepted beat plus pointer/level state.
module tb_fifo_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] wr_ptr_gray_i = 4'd0;
    logic       mem_rd_en_o;
    logic [2:0] mem_rd_addr_o;
    logic [7:0] mem_data_i = 8'd0;
    logic [3:0] rd_ptr_gray_o;
    logic       m_valid_o;
    logic [7:0] m_data_o;
    logic       m_ready_i = 1'b0;
    logic       empty_o;
    logic [3:0] level_o;
    logic       overflow_err_o;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem [8];
    logic [7:0] exp_q [$];
    logic [3:0] tb_wr = 4'd0;
    logic [3:0] exp_rd = 4'd0;
    logic [3:0] rd_before;
    logic [3:0] mlev;
    logic [7:0] exp_b;
    logic [7:0] held = 8'd0;
    logic       stall_prev = 1'b0;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    fifo_rd_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_ptr_gray_i  (wr_ptr_gray_i),
        .mem_rd_en_o    (mem_rd_en_o),
        .mem_rd_addr_o  (mem_rd_addr_o),
        .mem_data_i     (mem_data_i),
        .rd_ptr_gray_o  (rd_ptr_gray_o),
        .m_valid_o      (m_valid_o),
        .m_data_o       (m_data_o),
        .m_ready_i      (m_ready_i),
        .empty_o        (empty_o),
        .level_o        (level_o),
        .overflow_err_o (overflow_err_o)
    );

    // One-cycle-latency memory.
    always @(posedge clk) begin
        if (mem_rd_en_o) mem_data_i <= mem[mem_rd_addr_o];
    end

    function automatic logic [3:0] g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            mem[tb_wr[2:0]] = base + 8'(i);
            exp_q.push_back(base + 8'(i));
            tb_wr = tb_wr + 4'd1;
        end
        wr_ptr_gray_i = g(tb_wr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_ptr_gray_i = 4'd0;
        tb_wr = 4'd0;
        exp_rd = 4'd0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(exp_q.size() == 0 && n < 200), 1);
    endtask

    // Monitor: pointer/level model plus scoreboard comparison of beats.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            mlev = tb_wr - exp_rd;
            check("level", int'(level_o), int'(mlev));
            check("empty", int'(empty_o), int'(mlev == 4'd0));
            check("rd_gray", int'(rd_ptr_gray_o), int'(g(exp_rd)));
            if (mem_rd_en_o) begin
                check("rd_addr", int'(mem_rd_addr_o), int'(exp_rd[2:0]));
                check("rd_allowed", int'(mlev != 4'd0 && mlev <= 4'd8), 1);
                exp_rd = exp_rd + 4'd1;
            end
            if (m_valid_o && stall_prev) check("hold_data", int'(m_data_o), int'(held));
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", int'(m_data_o), -1);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("beat", int'(m_data_o), int'(exp_b));
                    $display("beat data=%02h expected=%02h", m_data_o, exp_b);
                end
            end
            stall_prev = m_valid_o && !m_ready_i;
            held = m_data_o;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", int'(m_valid_o), 0);
        check("rst_empty", int'(empty_o), 1);
        check("rst_level", int'(level_o), 0);
        check("rst_rd_gray", int'(rd_ptr_gray_o), 0);
        check("rst_rd_en", int'(mem_rd_en_o), 0);
        check("rst_data", int'(m_data_o), 0);
        check("rst_overflow", int'(overflow_err_o), 0);
        wr_ptr_gray_i = 4'b0001;
        #1;
        check("rst_rd_en_forced", int'(mem_rd_en_o), 0);
        wr_ptr_gray_i = 4'd0;
        tick();
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Single entry
        m_ready_i = 1'b1;
        tick();
        write_bytes(1, 8'hA5);
        @(negedge clk);
        check("single_rd_en", int'(mem_rd_en_o), 1);
        check("single_addr", int'(mem_rd_addr_o), 0);
        check("single_valid_n0", int'(m_valid_o), 0);
        @(negedge clk);
        check("single_rd_en_n1", int'(mem_rd_en_o), 0);
        check("single_valid_n1", int'(m_valid_o), 0);
        @(negedge clk);
        check("single_valid_n2", int'(m_valid_o), 1);
        check("single_data", int'(m_data_o), 8'hA5);
        @(negedge clk);
        check("single_empty", int'(empty_o), 1);
        check("single_rd_gray", int'(rd_ptr_gray_o), 1);
        check("single_valid_done", int'(m_valid_o), 0);

        // Burst of 8 with ready held high: 8 back-to-back beats
        tick();
        write_bytes(8, 8'h10);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            check("burst_valid", int'(m_valid_o), int'(i >= 2 && i <= 9));
        end
        check("burst_level_end", int'(level_o), 0);
        check("burst_all_seen", exp_q.size(), 0);

        // Backpressure: only two reads while stalled, head held
        tick();
        m_ready_i = 1'b0;
        rd_before = exp_rd;
        write_bytes(5, 8'h20);
        repeat (6) @(negedge clk);
        check("bp_reads", int'(exp_rd - rd_before), 2);
        check("bp_valid", int'(m_valid_o), 1);
        check("bp_head", int'(m_data_o), 8'h20);
        tick();
        m_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_drain_valid", int'(m_valid_o), 1);
        end
        drain("bp_drain");

        // Pointer and address wrap: 20 bytes in chunks of 4
        tick();
        for (int k = 0; k < 5; k++) begin
            write_bytes(4, 8'(k * 4));
            repeat (4) tick();
        end
        drain("wrap_drain");
        check("wrap_overflow", int'(overflow_err_o), 0);
        check("wrap_rd_count", int'(exp_rd), int'(tb_wr));

        // Overflow: level 9 with the read pointer at 0
        tick();
        do_reset();
        tick();
        tb_wr = 4'd9;
        wr_ptr_gray_i = g(4'd9);
        @(negedge clk);
        check("ovf_rd_en", int'(mem_rd_en_o), 0);
        check("ovf_not_yet", int'(overflow_err_o), 0);
        @(negedge clk);
        check("ovf_set", int'(overflow_err_o), 1);
        repeat (3) @(negedge clk);
        check("ovf_held", int'(overflow_err_o), 1);
        check("ovf_no_reads", int'(exp_rd), 0);
        tick();
        tb_wr = 4'd0;
        wr_ptr_gray_i = 4'd0;
        @(negedge clk);
        check("ovf_sticky", int'(overflow_err_o), 1);

        // Reset in the middle of a burst
        tick();
        do_reset();
        @(negedge clk);
        check("rst_clears_ovf", int'(overflow_err_o), 0);
        tick();
        write_bytes(6, 8'h40);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(m_valid_o), 0);
        check("mid_rst_data", int'(m_data_o), 0);
        check("mid_rst_rd_gray", int'(rd_ptr_gray_o), 0);
        check("mid_rst_addr", int'(mem_rd_addr_o), 0);
        check("mid_rst_rd_en", int'(mem_rd_en_o), 0);
        check("mid_rst_overflow", int'(overflow_err_o), 0);
        wr_ptr_gray_i = 4'd0;
        tb_wr = 4'd0;
        exp_rd = 4'd0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_valid", int'(m_valid_o), 0);
        check("post_rst_level", int'(level_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
